// File: rtl/memory_bus_responder.sv
// memory_bus_responder
//   Word-organised memory slave for a core MEM stage. It has byte-lane strobes,
//   fault detection, and optional wait-state insertion.
//
//   Optional feature macro: MEM_RESPONDER_WAIT_EN
//     defined   : IDLE/WAIT/RESPOND FSM inserts WAIT_STATES stall cycles per access
//     undefined : every request is answered combinationally in the cycle it is seen
//
//   Ports
//     clk          in   1   clock, rising edge
//     reset        in   1   asynchronous, active-high
//     address      in  32   byte address
//     dataIn       in  32   write data
//     dataOut      out 32   read data (valid only in the response cycle, else 0)
//     readWrite    in   1   1 = write, 0 = read
//     columnStrobe in   4   byte-lane enables; 4'b0000 = no request
//     stall        out  1   holds the MEM stage while the access is pending
//     busFault     out  1   one-cycle pulse in the response cycle of a bad access
module memory_bus_responder #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned WAIT_STATES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    input  logic        readWrite,
    input  logic [3:0]  columnStrobe,
    output logic        stall,
    output logic        busFault
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    if (WAIT_STATES > 15) begin : g_cfg_check
        $error("memory_bus_responder: WAIT_STATES must be 0..15");
    end

    logic [31:0]      mem [DEPTH_WORDS];
    logic             req;
    logic             respond;
    logic             stall_c;
    logic [32:0]      offset;
    logic             in_range;
    logic             legal_strobe;
    logic             misaligned;
    logic             fault;
    logic [IDX_W-1:0] idx;
    logic [31:0]      lane_mask;

    assign req = |columnStrobe;

    // 33-bit offset so an address below the base shows up as a borrow and the
    // top of the window may sit at 2^32 without wrapping.
    assign offset   = {1'b0, address} - {1'b0, BASE_ADDRESS};
    assign in_range = !offset[32] && (offset < LIMIT);
    assign idx      = offset[IDX_W+1:2];

    always_comb begin
        legal_strobe = 1'b0;
        misaligned   = 1'b0;
        case (columnStrobe)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: legal_strobe = 1'b1;
            4'b0011, 4'b1100, 4'b1111: begin
                legal_strobe = 1'b1;
                misaligned   = |address[1:0];
            end
            default: legal_strobe = 1'b0;
        endcase
    end

    assign fault = !in_range || !legal_strobe || misaligned;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (columnStrobe[i]) lane_mask[8*i +: 8] = 8'hFF;
        end
    end

`ifdef MEM_RESPONDER_WAIT_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] WS     = 4'(WAIT_STATES);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // The IDLE cycle that first sees a request is itself a stall cycle, so the
    // WAIT exit test uses the incremented count: WAIT_STATES stalls in total.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        respond = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WS == 4'd0) begin
                        respond = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = 4'd1;
                        state_d = (WS == 4'd1) ? S_RESP : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q + 4'd1 == WS) state_d = S_RESP;
            end
            S_RESP: begin
                respond = 1'b1;
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    always_comb begin
        stall_c = 1'b0;
        respond = req;
    end
`endif

    // Outputs are gated by reset so they drop the moment reset rises.
    logic respond_ok;
    assign respond_ok = respond && !reset;
    assign stall      = stall_c && !reset;
    assign busFault   = respond_ok && fault;
    assign dataOut    = (respond_ok && !fault && !readWrite) ? (mem[idx] & lane_mask) : 32'h0;

    // Array is never reset; a write only commits on the edge that ends a clean
    // response cycle.
    always_ff @(posedge clk) begin
        if (respond_ok && readWrite && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (columnStrobe[i]) mem[idx][8*i +: 8] <= dataIn[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_responder.sv
module tb_memory_bus_responder;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          WS    = 2;
`ifdef MEM_RESPONDER_WAIT_EN
    localparam int EXP_WS = WS;
`else
    localparam int EXP_WS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] dataIn = '0;
    logic [31:0] dataOut;
    logic        readWrite = 1'b0;
    logic [3:0]  columnStrobe = '0;
    logic        stall;
    logic        busFault;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [DEPTH];

    memory_bus_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDRESS(BASE),
        .WAIT_STATES (WS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .dataIn      (dataIn),
        .dataOut     (dataOut),
        .readWrite   (readWrite),
        .columnStrobe(columnStrobe),
        .stall       (stall),
        .busFault    (busFault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_fault(input logic [31:0] a, input logic [3:0] s);
        longint la = longint'(a);
        longint lo = longint'(BASE);
        bit in_rng = (la >= lo) && (la < lo + 4 * DEPTH);
        bit legal = (s == 4'h1) || (s == 4'h2) || (s == 4'h4) || (s == 4'h8) ||
                    (s == 4'h3) || (s == 4'hC) || (s == 4'hF);
        bit wide = (s == 4'h3) || (s == 4'hC) || (s == 4'hF);
        return !in_rng || !legal || (wide && (a % 4 != 0));
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (s[i]) m |= 32'hFF << (8 * i);
        return m;
    endfunction

    // Entered at posedge+1; leaves at posedge+1 after the response cycle.
    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic rw, input logic [3:0] s, output logic [31:0] rdata);
        int          stalls = 0;
        bit          got = 0;
        bit          noisy = 0;
        logic [31:0] dout = 'x;
        logic        flt = 1'bx;
        bit          f = exp_fault(a, s);
        int          w = (a - BASE) / 4;
        logic [31:0] exp_rd = (rw || f) ? 32'h0 : (model[w] & byte_mask(s));
        address = a; dataIn = d; readWrite = rw; columnStrobe = s;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (stall === 1'b1) begin
                stalls++;
                if (dataOut !== 32'h0 || busFault !== 1'b0) noisy = 1;
            end else begin
                got = 1; dout = dataOut; flt = busFault;
            end
        end
        @(posedge clk); #1;
        columnStrobe = 4'h0; readWrite = 1'b0;
        chk({tag, " responded"}, 32'(got), 32'd1);
        chk({tag, " stall cycles"}, 32'(stalls), 32'(EXP_WS));
        chk({tag, " quiet while stalled"}, 32'(noisy), 32'd0);
        chk({tag, " busFault"}, 32'(flt), 32'(f));
        if (!rw) chk({tag, " dataOut"}, dout, exp_rd);
        if (rw && !f) model[w] = (model[w] & ~byte_mask(s)) | (d & byte_mask(s));
        rdata = dout;
    endtask

    initial begin
        logic [31:0] rd;
        // Reset state, with a request present to show reset masks it.
        address = 32'h10; columnStrobe = 4'hF; readWrite = 1'b0;
        #12;
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset busFault", 32'(busFault), 32'd0);
        chk("reset dataOut", dataOut, 32'h0);
        columnStrobe = 4'h0;
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) access("init", BASE + 32'(4 * i), $urandom, 1'b1, 4'hF, rd);

        access("wr deadbeef", 32'h10, 32'hDEADBEEF, 1'b1, 4'hF, rd);
        access("rd deadbeef", 32'h10, 32'h0, 1'b0, 4'hF, rd);
        chk("deadbeef literal", rd, 32'hDEADBEEF);

        access("wr byte a5", 32'h10, 32'h00A5_0000, 1'b1, 4'h4, rd);
        access("rd after byte", 32'h10, 32'h0, 1'b0, 4'hF, rd);
        chk("dea5beef literal", rd, 32'hDEA5BEEF);

        access("rd past top", BASE + 32'(4 * DEPTH), 32'h0, 1'b0, 4'hF, rd);
        access("wr misaligned half", 32'h12, 32'h1234_5678, 1'b1, 4'h3, rd);
        access("rd after bad half", 32'h10, 32'h0, 1'b0, 4'hF, rd);
        chk("word 0x10 kept", rd, 32'hDEA5BEEF);
        access("rd lane3 only", 32'h10, 32'h0, 1'b0, 4'h8, rd);
        chk("lane3 literal", rd, 32'hDE00_0000);

        // Reset in the middle of a write to 0x20.
        address = 32'h20; dataIn = 32'hCAFE_F00D; readWrite = 1'b1; columnStrobe = 4'hF;
        if (EXP_WS > 0) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("abort stall", 32'(stall), 32'd0);
        chk("abort busFault", 32'(busFault), 32'd0);
        chk("abort dataOut", dataOut, 32'h0);
        @(posedge clk); #1;
        columnStrobe = 4'h0; readWrite = 1'b0; reset = 1'b0;
        access("rd 0x20 after abort", 32'h20, 32'h0, 1'b0, 4'hF, rd);

        // Back-to-back write then read of 0x04.
        access("b2b wr 0x04", 32'h04, 32'h0BAD_C0DE, 1'b1, 4'hF, rd);
        access("b2b rd 0x04", 32'h04, 32'h0, 1'b0, 4'hF, rd);
        chk("b2b literal", rd, 32'h0BAD_C0DE);

        for (int n = 0; n < 40; n++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [31:0] a;
            if (r == 0)      a = BASE + 32'(4 * DEPTH) + $urandom_range(0, 255);
            else if (r == 1) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else             a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            access("random", a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
